stream_rr_fifo: RTL and testbench

- Parametrised successor to the single-channel valid/ready/data stream reader.
- Merges NCHAN independent valid/ready/data input streams into one output stream.
- Uses a round-robin arbiter feeding a DEPTH-entry FIFO.
- Sits between multiple stream producers (interface-style valid/ready/data bundles) and a single downstream consumer; decouples backpressure with registered storage.

---
 rtl/stream_rr_fifo.sv | 137 +++++++++++++
 tb/tb_stream_rr_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_fifo.sv
// stream_rr_fifo
//   Merges NCHAN valid/ready/data input streams into one output stream.
//   A round-robin arbiter selects one channel per cycle and writes its beat
//   into a DEPTH-entry FIFO. The output side is a plain valid/ready stream
//   driven from the FIFO head.
//
//   Optional feature, enabled by defining STREAM_RR_FIFO_CHAN_ID_EN:
//   each beat also stores its source channel index, presented on out_id
//   alongside out_data.
//
//   in_ready depends only on in_valid, the arbiter pointer, the occupancy
//   and rst. It never depends on out_ready. A full FIFO refuses a push even
//   when a pop happens in the same cycle.
module stream_rr_fifo #(
    parameter int WIDTH = 32,
    parameter int NCHAN = 4,
    parameter int DEPTH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NCHAN-1:0]                           in_valid,
    output logic [NCHAN-1:0]                           in_ready,
    input  logic [NCHAN*WIDTH-1:0]                     in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [WIDTH-1:0]                           out_data,
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
    output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0] out_id,
`endif
    output logic [$clog2(DEPTH):0]                     level
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    // A single channel still needs a 1-bit index; it is held at 0.
    localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic [CW-1:0]    r_rr_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
    logic [CW-1:0]    r_id_mem [DEPTH];
`endif

    logic             w_full;
    logic             w_empty;
    logic             w_grant_vld;
    logic [CW-1:0]    w_grant_idx;
    logic [NCHAN-1:0] w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_data;

    assign w_full  = (r_count == CNTW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Round-robin search: first valid channel starting at r_rr_ptr, wrapping.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (!w_grant_vld && in_valid[(int'(r_rr_ptr) + k) % NCHAN]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CW'((int'(r_rr_ptr) + k) % NCHAN);
            end
        end
    end

    // Only the granted channel sees ready, and only when there is room and
    // the block is not in reset.
    always_comb begin
        w_in_ready = '0;
        if (w_grant_vld && !w_full && !rst) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    assign in_ready    = w_in_ready;
    assign w_push      = |(in_valid & w_in_ready);
    assign w_pop       = out_valid & out_ready;
    assign w_push_data = in_data[int'(w_grant_idx)*WIDTH +: WIDTH];

    // Storage write: the granted beat lands at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Its contents are only ever
        // read through r_rd_ptr while r_count says the entry is live, so
        // clearing it would add logic without changing behaviour.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
            r_id_mem[r_wr_ptr] <= w_grant_idx;
`endif
        end
    end

    // Pointer, occupancy and arbiter state, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                // The channel after the winner gets first look next time.
                if (int'(w_grant_idx) == NCHAN - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_grant_idx + CW'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign level     = r_count;
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
    assign out_id    = r_id_mem[r_rd_ptr];
`endif

endmodule

// File: tb/tb_stream_rr_fifo.sv
// tb_stream_rr_fifo
//   Directed stimulus for stream_rr_fifo (NCHAN=4, DEPTH=8, WIDTH=32).
//   Stimulus pushes expected beats into a scoreboard queue; a monitor pops
//   and compares whenever the output handshake is about to complete.
//   Define STREAM_RR_FIFO_CHAN_ID_EN to also compare out_id.
module tb_stream_rr_fifo;

    localparam int WIDTH = 32;
    localparam int NCHAN = 4;
    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NCHAN-1:0]       in_valid;
    logic [NCHAN-1:0]       in_ready;
    logic [NCHAN*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [3:0]             level;
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
    logic [1:0]             out_id;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    stream_rr_fifo #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
        .out_id    (out_id),
`endif
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [WIDTH-1:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    task automatic expect_beat(input logic [WIDTH-1:0] d, input int ch);
        exp_t e;
        e.data = d;
        e.id   = ch[1:0];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        in_valid  = '0;
        for (int i = 0; i < 40 && out_valid; i++) tick();
        check({name, "_empty"}, out_valid, 0);
        check({name, "_level"}, level, 0);
    endtask

    // Monitor: on the falling edge, a beat with valid & ready will be consumed
    // at the next rising edge, so compare it against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no beat", out_data);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", out_data, mon_e.data);
`ifdef STREAM_RR_FIFO_CHAN_ID_EN
                check("sb_id", out_id, mon_e.id);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        logic acc;

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        in_valid = '1;
        #1 check("rst_in_ready", in_ready, 0);
        in_valid = '0;
        rst      = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);

        // Basic pass-through on channel 2.
        set_data(2, 32'hA5A5_0001);
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        expect_beat(32'hA5A5_0001, 2);
        #1 check("pass_in_ready", in_ready, 4'b0100);
        tick();
        in_valid = '0;
        #1;
        check("pass_out_valid", out_valid, 1);
        check("pass_level1", level, 1);
        tick();
        #1;
        check("pass_level0", level, 0);
        check("pass_out_valid0", out_valid, 0);

        // Round-robin with all channels valid.
        do_reset();
        for (int i = 0; i < NCHAN; i++) set_data(i, 32'h10 + i);
        in_valid  = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) expect_beat(32'h10 + (k % 4), k % 4);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_grant", in_ready, 64'(1) << (k % 4));
            check("rr_onehot", $onehot0(in_ready), 1);
            tick();
        end
        in_valid = '0;
        tick();
        tick();
        #1 check("rr_level", level, 0);

        // Fill to full from channel 0, then backpressure release.
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            set_data(0, k);
            expect_beat(k, 0);
            #1 check("fill_ready", in_ready, 4'b0001);
            tick();
        end
        set_data(0, 8);
        #1;
        check("full_ready8", in_ready, 0);
        check("full_level", level, 8);
        tick();
        #1;
        check("full_ready8b", in_ready, 0);
        check("full_level_b", level, 8);
        out_ready = 1'b1;
        #1 check("full_pop_ready", in_ready, 0);
        tick();
        #1;
        check("full_after_pop", level, 7);
        check("full_ready_room", in_ready, 4'b0001);
        expect_beat(8, 0);
        tick();
        set_data(0, 9);
        expect_beat(9, 0);
        #1;
        check("full_ready9", in_ready, 4'b0001);
        check("full_level7", level, 7);
        tick();
        drain("fill_drain");

        // Full with simultaneous pop, channel 1 sustained traffic.
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            set_data(1, 32'h100 + k);
            expect_beat(32'h100 + k, 1);
            tick();
        end
        set_data(1, 32'h108);
        #1 check("fp_level8", level, 8);
        out_ready = 1'b1;
        #1 check("fp_pop_only", in_ready, 0);
        tick();
        #1 check("fp_level7", level, 7);
        for (int k = 8; k < 12; k++) begin
            set_data(1, 32'h100 + k);
            expect_beat(32'h100 + k, 1);
            #1;
            check("fp_ready", in_ready, 4'b0010);
            check("fp_level_hold", level, 7);
            tick();
        end
        drain("fp_drain");

        // Wrap-around: 20 beats from channel 3, out_ready toggling.
        for (int k = 0; k < 20; k++) expect_beat(k, 3);
        sent     = 0;
        in_valid = 4'b1000;
        for (int cyc = 0; cyc < 200 && sent < 20; cyc++) begin
            set_data(3, sent);
            out_ready = (cyc % 2 == 0);
            #1;
            acc = in_ready[3];
            check("wrap_level_max", level <= 8, 1);
            tick();
            if (acc) sent++;
        end
        check("wrap_sent", sent, 20);
        drain("wrap_drain");

        // Reset mid-stream with level 5 and all channels requesting.
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            set_data(1, 32'h200 + k);
            tick();
        end
        #1 check("mr_level5", level, 5);
        for (int i = 0; i < NCHAN; i++) set_data(i, 32'h30 + i);
        in_valid = '1;
        rst      = 1'b1;
        #1 check("mr_ready_in_rst", in_ready, 0);
        sb.delete();
        tick();
        rst = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_level", level, 0);
        check("mr_grant_ch0", in_ready, 4'b0001);
        expect_beat(32'h30, 0);
        tick();
        in_valid = '0;
        #1 check("mr_level1", level, 1);
        drain("mr_drain");

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
